sad_min_reducer: RTL and testbench
==================================

Name: sad_min_reducer

Overview:
- Consumer end of the SAD stage-6/7 pipeline register. It reduces the per-beat pair of candidate minima (A and B) into one global minimum for each search window.
- A beat is marked as the last of its window by TriggerBoss. On that beat the block publishes the winning index, value and beat count through a one-deep valid/ready result buffer.
- The SAD pipeline never stalls, so accumulation always proceeds. Results that cannot be buffered are dropped and flagged.

Parameters:
- IDX_W, 16, width of candidate index
- VAL_W, 14, width of SAD value
- CNT_W, 16, width of per-window beat counter

Ports:
- clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- SAD7_Valid  in  1  beat qualifier; other SAD7_* inputs ignored when low
- SAD7_TriggerBoss  in  1  last beat of current window; only honoured with SAD7_Valid
- SAD7_IndexOfMinA  in  IDX_W  candidate A index
- SAD7_ValueOfMinA  in  VAL_W  candidate A SAD value
- SAD7_IndexOfMinB  in  IDX_W  candidate B index
- SAD7_ValueOfMinB  in  VAL_W  candidate B SAD value
- Result_Valid  out  1  result buffer full
- Result_Ready  in  1  downstream accepts result when high with Result_Valid
- Result_Index  out  IDX_W  index of window minimum
- Result_Value  out  VAL_W  window minimum SAD value
- Result_Count  out  CNT_W  valid beats in window, TriggerBoss beat included
- Overrun  out  1  sticky: a completed window result was dropped
- Busy  out  1  high in ACCUM state

Behaviour:
- Reset (synchronous, active-high) sets:
  - state IDLE, running min value all-ones, running index 0, beat count 0
  - Result_Valid 0, Result_Index 0, Result_Value 0, Result_Count 0
  - Overrun 0, Busy 0
- Reset mid-window discards the partial accumulation. Reset with Result_Valid high discards the held result.
- Per-beat pair select (combinational): B wins only if ValueOfMinB < ValueOfMinA, so a tie goes to A.
- Running update: the pair winner replaces the running min only if strictly less. Equal values keep the earlier candidate.
- On the first beat of a window the pair winner loads unconditionally; the running min is not compared.
- Beat count:
  - first beat loads 1
  - each later valid beat increments by 1
  - saturates at 2^CNT_W-1, no wrap
- States:
  - IDLE: Busy=0.
    - Valid & !TriggerBoss: load first beat, go to ACCUM.
    - Valid & TriggerBoss: single-beat window; publish pair winner with count 1 and stay in IDLE.
  - ACCUM: Busy=1.
    - Valid & !TriggerBoss: update, stay in ACCUM.
    - Valid & TriggerBoss: fold beat in, publish, go to IDLE.
    - !Valid: hold all state.
- Publish:
  - The final value equals the fold of the running min with the last beat's winner.
  - Result_* registers are written at the clock edge that samples the TriggerBoss beat. Result_Valid goes high the following cycle, so latency is 1 clock.
- Result handshake:
  - Transfer occurs when Result_Valid & Result_Ready.
  - Result_Index, Result_Value and Result_Count stay stable while Result_Valid=1 and not accepted.
  - Result_Valid clears after transfer unless a new publish happens in the same cycle.
- Simultaneous transfer and publish: the new result loads and Result_Valid stays 1. This is not an overrun.
- Publish while Result_Valid=1 and Result_Ready=0: the new result is dropped, the held result is kept, and Overrun is set. Overrun clears only on Reset.
- The next window's accumulation always proceeds, regardless of result-buffer state.
- TriggerBoss with SAD7_Valid=0 is ignored entirely.
- Values are unsigned. No arithmetic is performed other than compares and the counter increment.

Test Plan:
- Single window, 3 beats, Result_Ready=1.
  - Beat 1: A=(5,100), B=(6,90). Beat 2: A=(7,95), B=(8,120). Beat 3 with TriggerBoss: A=(9,91), B=(10,300).
  - Required: one cycle after beat 3, Result_Valid=1, Index=6, Value=90, Count=3. Busy was high for beats 2–3.
- Tie rules.
  - Beat 1: A=(1,50), B=(2,50). Beat 2 with TriggerBoss: A=(3,50), B=(4,60).
  - Required: Index=1, Value=50, Count=2.
- Single-beat window from IDLE.
  - Valid & TriggerBoss with A=(20,7), B=(21,3).
  - Required: next cycle Index=21, Value=3, Count=1. Busy never asserts.
- Backpressure and overrun.
  - Complete window 1 (min idx 6, value 90) with Result_Ready=0. Complete window 2 (min idx 11, value 40) while still not ready.
  - Required: result holds idx 6 / value 90 and Overrun=1.
  - Then raise Result_Ready: transfer occurs and Result_Valid drops to 0.
- Transfer and publish in the same cycle.
  - Result_Ready=1 on the cycle window 2 publishes, with window 1 held.
  - Required: window 2 result is loaded, Result_Valid stays 1, Overrun stays 0.
- Invalid gaps and reset.
  - Insert Valid=0 cycles, one carrying TriggerBoss=1 and value 0 mid-window; the window result is unaffected.
  - Assert Reset mid-window with 2 beats accumulated; the next 1-beat window reports Count=1.
  - All outputs read 0 in the cycle after Reset.

Source files
------------

// File: rtl/sad_min_reducer.sv
// Folds the per-beat A/B candidate minima into one minimum per search window and
// publishes index, value and beat count through a one-deep valid/ready result buffer.
module sad_min_reducer #(
    parameter int IDX_W = 16,
    parameter int VAL_W = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             SAD7_Valid,
    input  logic             SAD7_TriggerBoss,
    input  logic [IDX_W-1:0] SAD7_IndexOfMinA,
    input  logic [VAL_W-1:0] SAD7_ValueOfMinA,
    input  logic [IDX_W-1:0] SAD7_IndexOfMinB,
    input  logic [VAL_W-1:0] SAD7_ValueOfMinB,
    output logic             Result_Valid,
    input  logic             Result_Ready,
    output logic [IDX_W-1:0] Result_Index,
    output logic [VAL_W-1:0] Result_Value,
    output logic [CNT_W-1:0] Result_Count,
    output logic             Overrun,
    output logic             Busy
);

    // Result handshake: a result moves downstream on any rising edge where
    // Result_Valid and Result_Ready are both high; the payload is frozen while
    // Result_Valid is high and not yet accepted.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [VAL_W-1:0] r_min_val;
    logic [IDX_W-1:0] r_min_idx;
    logic [CNT_W-1:0] r_cnt;

    logic             r_res_valid;
    logic [IDX_W-1:0] r_res_idx;
    logic [VAL_W-1:0] r_res_val;
    logic [CNT_W-1:0] r_res_cnt;
    logic             r_overrun;

    logic             w_b_wins;
    logic [IDX_W-1:0] w_pair_idx;
    logic [VAL_W-1:0] w_pair_val;
    logic [IDX_W-1:0] w_fold_idx;
    logic [VAL_W-1:0] w_fold_val;
    logic [CNT_W-1:0] w_fold_cnt;
    logic             w_publish;
    logic             w_xfer;
    logic             w_load;

    // Ties between A and B go to A.
    assign w_b_wins   = SAD7_ValueOfMinB < SAD7_ValueOfMinA;
    assign w_pair_idx = w_b_wins ? SAD7_IndexOfMinB : SAD7_IndexOfMinA;
    assign w_pair_val = w_b_wins ? SAD7_ValueOfMinB : SAD7_ValueOfMinA;

    always_comb begin
        w_state_nxt = r_state;
        w_fold_idx  = w_pair_idx;
        w_fold_val  = w_pair_val;
        w_fold_cnt  = CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                if (SAD7_Valid && !SAD7_TriggerBoss) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // Only a strictly smaller value displaces the earlier candidate.
                if (!(w_pair_val < r_min_val)) begin
                    w_fold_idx = r_min_idx;
                    w_fold_val = r_min_val;
                end
                w_fold_cnt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
                if (SAD7_Valid && SAD7_TriggerBoss) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_min_val <= {VAL_W{1'b1}};
            r_min_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (SAD7_Valid) begin
                r_min_val <= w_fold_val;
                r_min_idx <= w_fold_idx;
                r_cnt     <= w_fold_cnt;
            end
        end
    end

    assign w_publish = SAD7_Valid && SAD7_TriggerBoss;
    assign w_xfer    = r_res_valid && Result_Ready;
    // A publish fits if the buffer is empty or is being drained on this same edge.
    assign w_load    = w_publish && (!r_res_valid || Result_Ready);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_val   <= '0;
            r_res_cnt   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_idx   <= w_fold_idx;
                r_res_val   <= w_fold_val;
                r_res_cnt   <= w_fold_cnt;
            end else if (w_xfer) begin
                r_res_valid <= 1'b0;
            end
            if (w_publish && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign Result_Valid = r_res_valid;
    assign Result_Index = r_res_idx;
    assign Result_Value = r_res_val;
    assign Result_Count = r_res_cnt;
    assign Overrun      = r_overrun;
    assign Busy         = (r_state == S_ACCUM);

endmodule

// File: tb/tb_sad_min_reducer.sv
// Bench for sad_min_reducer: directed windows with literal expectations plus random
// traffic, all outputs compared every cycle against a window-level reference model.
module tb_sad_min_reducer;

    localparam int IDX_W = 16;
    localparam int VAL_W = 14;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             valid;
    logic             trig;
    logic [IDX_W-1:0] a_idx;
    logic [VAL_W-1:0] a_val;
    logic [IDX_W-1:0] b_idx;
    logic [VAL_W-1:0] b_val;
    logic             rdy;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [VAL_W-1:0] res_val;
    logic [CNT_W-1:0] res_cnt;
    logic             overrun;
    logic             busy;

    int total;
    int bad;
    bit cmp_en;

    sad_min_reducer #(.IDX_W(IDX_W), .VAL_W(VAL_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .Reset            (rst),
        .SAD7_Valid       (valid),
        .SAD7_TriggerBoss (trig),
        .SAD7_IndexOfMinA (a_idx),
        .SAD7_ValueOfMinA (a_val),
        .SAD7_IndexOfMinB (b_idx),
        .SAD7_ValueOfMinB (b_val),
        .Result_Valid     (res_valid),
        .Result_Ready     (rdy),
        .Result_Index     (res_idx),
        .Result_Value     (res_val),
        .Result_Count     (res_cnt),
        .Overrun          (overrun),
        .Busy             (busy)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every candidate of the window in arrival order (A before B
    // within a beat); the winner is the first occurrence of the smallest value.
    logic [IDX_W-1:0] idx_q[$];
    logic [VAL_W-1:0] val_q[$];
    int               m_beats;
    logic             m_rv;
    logic [IDX_W-1:0] m_idx;
    logic [VAL_W-1:0] m_val;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovr;
    logic             m_busy;

    always @(posedge clk) begin
        int  best;
        bit  xfer;
        if (rst) begin
            idx_q.delete();
            val_q.delete();
            m_beats = 0;
            m_rv  = 1'b0;
            m_idx = '0;
            m_val = '0;
            m_cnt = '0;
            m_ovr = 1'b0;
        end else begin
            xfer = m_rv && rdy;
            if (valid) begin
                idx_q.push_back(a_idx);
                val_q.push_back(a_val);
                idx_q.push_back(b_idx);
                val_q.push_back(b_val);
                m_beats++;
            end
            if (valid && trig) begin
                best = 0;
                for (int i = 1; i < val_q.size(); i++)
                    if (val_q[i] < val_q[best]) best = i;
                if (!m_rv || rdy) begin
                    m_rv  = 1'b1;
                    m_idx = idx_q[best];
                    m_val = val_q[best];
                    m_cnt = CNT_W'((m_beats > CNT_MAX) ? CNT_MAX : m_beats);
                end else begin
                    m_ovr = 1'b1;
                end
                idx_q.delete();
                val_q.delete();
                m_beats = 0;
            end else if (xfer) begin
                m_rv = 1'b0;
            end
        end
        m_busy = (m_beats != 0);
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", 32'(res_valid), 32'(m_rv));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
            if (m_rv) begin
                chk("cyc_index", 32'(res_idx), 32'(m_idx));
                chk("cyc_value", 32'(res_val), 32'(m_val));
                chk("cyc_count", 32'(res_cnt), 32'(m_cnt));
            end
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic beat(input logic v, input logic t, input int ai, input int av,
                        input int bi, input int bv);
        @(posedge clk);
        #2;
        valid = v;
        trig  = t;
        a_idx = IDX_W'(ai);
        a_val = VAL_W'(av);
        b_idx = IDX_W'(bi);
        b_val = VAL_W'(bv);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic chk_res(input string nm, input int v, input int ix, input int vl, input int c);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(res_valid), 32'(v));
        chk({nm, "_index"}, 32'(res_idx), 32'(ix));
        chk({nm, "_value"}, 32'(res_val), 32'(vl));
        chk({nm, "_count"}, 32'(res_cnt), 32'(c));
    endtask

    initial begin
        total = 0;
        bad = 0;
        cmp_en = 1'b0;
        rst = 1'b1;
        rdy = 1'b0;
        valid = 1'b0;
        trig = 1'b0;
        a_idx = '0;
        a_val = '0;
        b_idx = '0;
        b_val = '0;

        idle();
        cmp_en = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_payload", {res_idx, res_val, 2'b00} | 32'(res_cnt), 0);

        // Three-beat window, consumer ready.
        rdy = 1'b1;
        beat(1, 0, 5, 100, 6, 90);
        beat(1, 0, 7, 95, 8, 120);
        @(negedge clk);
        chk("w3_busy_b2", 32'(busy), 1);
        beat(1, 1, 9, 91, 10, 300);
        @(negedge clk);
        chk("w3_busy_b3", 32'(busy), 1);
        idle();
        chk_res("w3", 1, 6, 90, 3);
        chk("model_pin_w3", {m_idx, m_val, 2'b00} | 32'(m_cnt), {16'd6, 14'd90, 2'b00} | 32'd3);
        chk("w3_busy_after", 32'(busy), 0);

        // Ties go to the earlier candidate.
        beat(1, 0, 1, 50, 2, 50);
        beat(1, 1, 3, 50, 4, 60);
        idle();
        chk_res("tie", 1, 1, 50, 2);

        // Single-beat window straight from idle.
        beat(1, 1, 20, 7, 21, 3);
        @(negedge clk);
        chk("single_busy_a", 32'(busy), 0);
        idle();
        chk_res("single", 1, 21, 3, 1);
        chk("single_busy_b", 32'(busy), 0);
        idle();
        idle();

        // Backpressure: second window is dropped, first is held.
        rdy = 1'b0;
        beat(1, 0, 5, 100, 6, 90);
        beat(1, 1, 9, 91, 10, 300);
        beat(1, 0, 11, 40, 12, 50);
        beat(1, 1, 13, 45, 14, 60);
        idle();
        chk_res("bp", 1, 6, 90, 2);
        chk("bp_overrun", 32'(overrun), 1);
        chk("model_pin_ovr", 32'(m_ovr), 1);
        idle();
        rdy = 1'b1;
        idle();
        @(negedge clk);
        chk("bp_drained", 32'(res_valid), 0);
        chk("bp_overrun_sticky", 32'(overrun), 1);

        // Transfer and publish on the same edge.
        idle();
        rst = 1'b1;
        rdy = 1'b0;
        idle();
        rst = 1'b0;
        beat(1, 0, 5, 100, 6, 90);
        beat(1, 1, 9, 91, 10, 300);
        beat(1, 0, 11, 40, 12, 50);
        beat(1, 1, 13, 45, 14, 60);
        rdy = 1'b1;
        idle();
        rdy = 1'b0;
        chk_res("xp", 1, 11, 40, 2);
        chk("xp_overrun", 32'(overrun), 0);

        // Invalid gaps, one carrying TriggerBoss with value 0.
        rdy = 1'b1;
        beat(1, 0, 5, 100, 6, 90);
        beat(0, 1, 30, 0, 31, 0);
        idle();
        beat(1, 1, 9, 91, 10, 300);
        idle();
        chk_res("gap", 1, 6, 90, 2);

        // Reset mid-window.
        beat(1, 0, 5, 100, 6, 90);
        beat(1, 0, 7, 95, 8, 120);
        idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 32'(res_valid), 0);
        chk("rst2_busy", 32'(busy), 0);
        chk("rst2_payload", {res_idx, res_val, 2'b00} | 32'(res_cnt), 0);
        beat(1, 1, 20, 7, 21, 3);
        idle();
        chk_res("post_rst", 1, 21, 3, 1);

        // Beat counter saturates instead of wrapping.
        for (int i = 0; i < 20; i++) beat(1, 0, 100 + i, 500 - i, 200 + i, 600);
        beat(1, 1, 1, 900, 2, 900);
        idle();
        chk_res("sat", 1, 119, 481, CNT_MAX);

        // Random traffic; small value range to provoke ties.
        for (int n = 0; n < 3000; n++) begin
            beat(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383))
                                             : int'($urandom_range(0, 63)));
            rdy = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 255) == 0);
        end
        rst = 1'b0;
        idle();
        idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
